// File: rtl/cpu_pkg.sv
// Shared definitions for the stack CPU sequencer and control decoder.
// Instruction words use MSB-first numbering [0:INSTR_W-1] to line up with the decoder.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 18;

    localparam logic [0:INSTR_W-1] HALT_WORD = 18'h3FFFF;

    // Instruction type bits and the jump-condition mask field
    localparam int TYPE_B0 = 0;
    localparam int TYPE_B1 = 1;
    localparam int JMP_LO  = 12;
    localparam int JMP_HI  = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } seq_state_e;

    // A jump is taken for type 00 when any masked condition flag is set
    function automatic logic jump_taken(input logic [0:INSTR_W-1] instr,
                                        input logic [5:0]         flags);
        logic tin;
        tin = ~instr[TYPE_B0] & ~instr[TYPE_B1];
        return tin & (|(instr[JMP_LO:JMP_HI] & flags));
    endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter: holds the fetch address and advances it either by
// one (wrapping) or to the datapath-selected jump target.
module seq_pc #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_take,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    always_comb begin
        pc_d = pc_q;
        if (i_load) begin
            pc_d = i_take ? i_target : pc_inc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: fetches over req/ack, holds the instruction register,
// strobes execute, stretches on stack busy and halts on the all-ones word.
module instr_sequencer #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [0:INSTR_W-1] i_imem_data,
    output logic [0:INSTR_W-1] o_instr,
    output logic               o_exec_en,
    input  logic               i_stk_busy,
    input  logic [5:0]         i_flags,
    input  logic [PC_W-1:0]    i_jmp_target,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_halted
);

    import cpu_pkg::*;

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [0:INSTR_W-1] instr_q;
    logic [0:INSTR_W-1] instr_d;
    logic               is_halt;
    logic               pc_load;
    logic               take;
    logic [PC_W-1:0]    pc;

    assign is_halt = (instr_q == HALT_WORD);
    assign take    = jump_taken(instr_q, i_flags);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_load = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (i_imem_ack) begin
                    instr_d = i_imem_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    pc_load = 1'b1;
                    state_d = i_stk_busy ? S_WAIT : S_FETCH;
                end
            end
            S_WAIT: begin
                if (!i_stk_busy) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    seq_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_seq_pc (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (pc_load),
        .i_take   (take),
        .i_target (i_jmp_target),
        .o_pc     (pc)
    );

    // Strobes come only from registered state and the registered IR
    assign o_imem_req  = (state_q == S_FETCH);
    assign o_exec_en   = (state_q == S_EXEC) && !is_halt;
    assign o_halted    = (state_q == S_HALT);
    assign o_instr     = instr_q;
    assign o_imem_addr = pc;
    assign o_pc        = pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected fetch addresses are queued
// when an instruction executes and checked when the next request appears.
module tb_instr_sequencer;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [0:17] imem_data = '0;
    logic [0:17] instr;
    logic        exec_en;
    logic        stk_busy = 1'b0;
    logic [5:0]  flags = '0;
    logic [15:0] jmp_target = '0;
    logic [15:0] pc;
    logic        halted;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] model_pc;
    logic [0:17] model_ir;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W     (16),
        .INSTR_W  (18),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_data  (imem_data),
        .o_instr      (instr),
        .o_exec_en    (exec_en),
        .i_stk_busy   (stk_busy),
        .i_flags      (flags),
        .i_jmp_target (jmp_target),
        .o_pc         (pc),
        .o_halted     (halted)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Fetch one word (ack after 'delay' idle request cycles), execute it with the
    // given flags/target, then stall for busy_n+1 WAIT cycles if busy_n >= 0.
    task automatic fetch_one(input logic [0:17] word, input int delay, input logic [5:0] fl,
                             input logic [15:0] tgt, input int busy_n, input string name);
        logic [15:0] want_addr;
        logic        is_halt;
        logic        tin;
        logic        take;
        logic [15:0] nxt;
        int          guard;
        guard = 0;
        want_addr = imem_addr;
        while (imem_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_timeout req=%b want 1", name, imem_req);
            return;
        end
        vectors++;
        if (exp_addr_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s addr_queue_empty got addr=%h", name, imem_addr);
        end else begin
            want_addr = exp_addr_q.pop_front();
            if (imem_addr !== want_addr || pc !== want_addr) begin
                miscompares++;
                $display("FAIL %s fetch_addr got addr=%h pc=%h want %h", name, imem_addr, pc, want_addr);
            end
        end
        for (int d = 0; d < delay; d++) begin
            vectors++;
            if (imem_req !== 1'b1 || imem_addr !== want_addr || instr !== model_ir || exec_en !== 1'b0) begin
                miscompares++;
                $display("FAIL %s slow_hold cyc%0d got req=%b addr=%h instr=%h exec=%b want 1 %h %h 0",
                         name, d, imem_req, imem_addr, instr, exec_en, want_addr, model_ir);
            end
            imem_data = 18'($urandom);
            @(negedge clk);
        end
        imem_ack  = 1'b1;
        imem_data = word;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 18'($urandom);
        model_ir  = word;
        is_halt   = (word == 18'h3FFFF);
        vectors++;
        if (instr !== model_ir || exec_en !== !is_halt || imem_req !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL %s exec_cycle got instr=%h exec=%b req=%b halted=%b want %h %b 0 0",
                     name, instr, exec_en, imem_req, halted, model_ir, !is_halt);
        end
        flags      = fl;
        jmp_target = tgt;
        stk_busy   = (busy_n >= 0);
        if (is_halt) begin
            @(negedge clk);
            stk_busy = 1'b0;
            for (int c = 0; c < 20; c++) begin
                imem_ack = 1'($urandom);
                vectors++;
                if (halted !== 1'b1 || imem_req !== 1'b0 || exec_en !== 1'b0 || pc !== model_pc ||
                    instr !== model_ir) begin
                    miscompares++;
                    $display("FAIL %s halt_cyc%0d got halted=%b req=%b exec=%b pc=%h instr=%h want 1 0 0 %h %h",
                             name, c, halted, imem_req, exec_en, pc, instr, model_pc, model_ir);
                end
                @(negedge clk);
            end
            imem_ack = 1'b0;
            return;
        end
        tin  = ~word[0] & ~word[1];
        take = tin & (|(word[12:17] & fl));
        nxt  = take ? tgt : model_pc + 16'd1;
        model_pc = nxt;
        exp_addr_q.push_back(nxt);
        @(negedge clk);
        if (busy_n >= 0) begin
            for (int w = 0; w <= busy_n; w++) begin
                flags      = 6'($urandom);
                jmp_target = 16'($urandom);
                imem_ack   = (w == busy_n) ? 1'b0 : 1'($urandom);
                vectors++;
                if (imem_req !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b0 || pc !== nxt) begin
                    miscompares++;
                    $display("FAIL %s wait_cyc%0d got req=%b exec=%b halted=%b pc=%h want 0 0 0 %h",
                             name, w, imem_req, exec_en, halted, pc, nxt);
                end
                if (w == busy_n) stk_busy = 1'b0;
                @(negedge clk);
            end
        end
        $display("txn %-10s word=%h pc_next=%h", name, word, nxt);
    endtask

    task automatic release_reset(input string name);
        exp_addr_q.delete();
        exp_addr_q.push_back(RST_PC);
        model_pc = RST_PC;
        model_ir = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_cycle got req=%b exec=%b halted=%b want 0 0 0", name, imem_req, exec_en, halted);
        end
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL %s first_req got req=%b addr=%h want 1 %h", name, imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b0 || pc !== RST_PC ||
            imem_addr !== RST_PC || instr !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_values got req=%b exec=%b halted=%b pc=%h addr=%h instr=%h",
                     imem_req, exec_en, halted, pc, imem_addr, instr);
        end
        imem_ack = 1'b0;
        release_reset("reset");
        fetch_one(18'h30000, 0, 6'h00, 16'h0000, -1, "first");
        fetch_one(18'h2ABCD, 0, 6'h3F, 16'h7777, -1, "second");
    endtask

    task automatic test_slow_memory;
        fetch_one(18'h12345, 3, 6'h00, 16'h0000, -1, "slow3");
        fetch_one(18'h23456, 1, 6'h00, 16'h0000, -1, "slow1");
    endtask

    task automatic test_jump;
        fetch_one(18'h00001, 0, 6'b000001, 16'h0200, -1, "jmp_take");
        fetch_one(18'h00001, 0, 6'b000000, 16'h0300, -1, "jmp_noflag");
        fetch_one(18'h20001, 0, 6'b111111, 16'h0400, -1, "jmp_tin0");
        fetch_one(18'h00020, 0, 6'b100000, 16'h0A5A, -1, "jmp_bit12");
        fetch_one(18'h00020, 0, 6'b011111, 16'h0B00, -1, "jmp_miss");
    endtask

    task automatic test_stall;
        fetch_one(18'h10000, 0, 6'h00, 16'h0000, 2, "stall2");
        fetch_one(18'h00004, 0, 6'b000100, 16'h0800, 0, "stall0_jmp");
    endtask

    task automatic test_wrap;
        fetch_one(18'h00001, 0, 6'b000001, 16'hFFFF, -1, "to_ffff");
        fetch_one(18'h00000, 0, 6'b111111, 16'h1234, -1, "wrap");
        fetch_one(18'h30000, 0, 6'h00, 16'h0000, -1, "after_wrap");
    endtask

    task automatic test_reset_mid_wait;
        fetch_one(18'h30003, 0, 6'h00, 16'h0000, 5, "pre_rst");
        // Reach WAIT with a pending stall, then pull reset between clock edges
        while (imem_req !== 1'b1) @(negedge clk);
        void'(exp_addr_q.pop_front());
        imem_ack = 1'b1;
        imem_data = 18'h10101;
        @(negedge clk);
        imem_ack = 1'b0;
        stk_busy = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0 || exec_en !== 1'b0 || halted !== 1'b0 || pc !== RST_PC ||
            imem_addr !== RST_PC || instr !== 18'h0) begin
            miscompares++;
            $display("FAIL rst_wait got req=%b exec=%b halted=%b pc=%h addr=%h instr=%h",
                     imem_req, exec_en, halted, pc, imem_addr, instr);
        end
        stk_busy = 1'b0;
        @(negedge clk);
        release_reset("rst_wait");
        fetch_one(18'h30000, 0, 6'h00, 16'h0000, -1, "post_rst");
    endtask

    task automatic test_halt;
        fetch_one(18'h3FFFF, 2, 6'h3F, 16'h0999, -1, "halt");
    endtask

    initial begin
        test_reset;
        test_slow_memory;
        test_jump;
        test_stall;
        test_wrap;
        test_reset_mid_wait;
        test_halt;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/execute sequencer for the 16-bit stack CPU. It fetches 18-bit instruction words from instruction memory over a req/ack handshake and holds them in an instruction register that drives the combinational control decoder. It pulses a one-cycle execute enable that qualifies all datapath and stack writes, and stretches execution while the stack is busy. It owns the program counter, including sequential increment and conditional jumps, and halts on a HALT word.

## Interface
- `PC_W`, 16, program counter / instruction address width
- `INSTR_W`, 18, instruction width; bit 0 is the MSB, matching the decoder
- `RESET_PC`, 0, PC value loaded on reset
- `i_clk` input 1: the single clock, rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `o_imem_req` output 1: fetch request.
- `o_imem_addr` output PC_W: fetch address, always equal to the PC.
- `i_imem_ack` input 1: fetch data valid this cycle.
- `i_imem_data` input [0:INSTR_W-1]: fetched word.
- `o_instr` output [0:INSTR_W-1]: instruction register, feeds the decoder.
- `o_exec_en` output 1: one-cycle execute strobe that gates every datapath write.
- `i_stk_busy` input 1: the stack or datapath needs extra cycles.
- `i_flags` input 6: condition flags, bit-aligned with `o_instr[12:17]`.
- `i_jmp_target` input PC_W: jump target already selected by the datapath (jSel).
- `o_pc` output PC_W: current PC.
- `o_halted` output 1: the sequencer is in HALT.

## Operation
- States:
  - **IDLE** is entered on reset and lasts 1 cycle. It always goes to FETCH.
  - **FETCH** asserts `o_imem_req`, with `o_imem_addr` set to PC. On `i_imem_ack`, `o_instr` loads `i_imem_data` and the state goes to EXEC. Without ack it stays in FETCH with no timeout.
  - **EXEC** asserts `o_exec_en` for exactly this cycle, then:
    - If `o_instr` equals all-ones (HALT), `o_exec_en` stays 0 and the state goes to HALT. PC is not changed.
    - Otherwise the PC is updated at the end of EXEC. The next state is WAIT if `i_stk_busy` is sampled 1 in EXEC, else FETCH.
  - **WAIT** holds while `i_stk_busy` is 1 and goes to FETCH in the first cycle it is 0. `o_exec_en` is 0 throughout.
  - **HALT** is terminal and exits only via reset. `o_halted` = 1 and `o_imem_req` = 0.
- Jump decision, evaluated in EXEC only:
  - `tin` = ~`o_instr[0]` & ~`o_instr[1]`.
  - `take` = `tin` & |(`o_instr[12:17]` & `i_flags`).
  - If `take`, PC is set to `i_jmp_target`. Otherwise PC is set to PC+1, modulo 2^PC_W, so 0xFFFF wraps to 0x0000.
- Flags and target are sampled in the EXEC cycle. Changes during WAIT are ignored.
- `i_imem_ack` is ignored outside FETCH, and `o_instr` holds its value.
- `i_stk_busy` matters only in EXEC and WAIT.
- A HALT word still completes its fetch. `o_instr` shows the HALT word.

## Timing
- Reset values (async on `i_rst_n`=0):
  - state IDLE
  - `o_imem_req` 0
  - PC and `o_imem_addr` = RESET_PC
  - `o_instr` 0
  - `o_exec_en` 0
  - `o_halted` 0
- Reset mid-fetch drops `o_imem_req` immediately, and the in-flight ack is discarded.
- Reset mid-WAIT abandons the instruction, and PC returns to RESET_PC.
- `o_imem_req`, `o_exec_en` and `o_halted` are decoded from registered state only, with no input-to-output combinational path.
- An ack in the same cycle as the request is legal.
- Best case is 2 cycles per instruction (FETCH, EXEC). Each busy cycle sampled adds 1 WAIT cycle, so busy high in EXEC plus n further cycles gives n+1 WAIT cycles.
- The first request goes out in cycle 2 after reset deassertion (cycle 1 is IDLE).
- The new PC appears on `o_imem_addr` in the cycle after EXEC.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (IDLE, FETCH, EXEC, WAIT, HALT)
  - `INSTR_W` and `PC_W`
  - `HALT_WORD` (18'h3FFFF)
  - the jump-field bit positions [12:17] and the type bits [0:1], which are shared with the decoder.
- One sub-module, `seq_pc`, contains the PC register, the incrementer, and the target/increment mux. It takes load-enable and take inputs.
- The FSM and the IR stay in the top level.

## Test plan
- **Reset and first fetch.** Stimulus: RESET_PC=0x0010, memory acks immediately. Required: `o_imem_req`=0 during reset and IDLE; req rises with addr 0x0010 in cycle 2 after reset release; `o_exec_en` pulses in the next cycle; the next addr is 0x0011.
- **Slow memory.** Stimulus: ack delayed 3 cycles. Required: req and addr held steady for 4 cycles, `o_instr` unchanged until the ack cycle, then a single `o_exec_en`.
- **Conditional jump.** Stimulus: `o_instr`=18'h00001 (tin=1, jump bit 17), `i_flags`=6'b000001, target 0x0200. Required: next addr is 0x0200. The same instruction with `i_flags`=0 gives PC+1. Instruction 18'h20001 (tin=0) never jumps.
- **Stack stall.** Stimulus: `i_stk_busy` high in EXEC and 2 more cycles. Required: exactly one `o_exec_en` pulse, 3 WAIT cycles, no req until busy is low, and PC advanced exactly once.
- **Wrap and HALT.** Stimulus: PC 0xFFFF with a non-jump instruction. Required: next addr is 0x0000. Fetching 18'h3FFFF gives `o_halted`=1, no `o_exec_en`, and req held at 0 for 20 cycles.
- **Async reset mid-WAIT.** Stimulus: assert `i_rst_n`=0 mid-WAIT. Required: all outputs take their reset values in the same cycle, and the first fetch after release is from RESET_PC.
